// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side (fetch/data) and shared-memory-side signals of
// the memory arbiter. The master modport is the arbiter's view; slave is the
// view of whatever surrounds it (requesters plus memory).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Instruction fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_stall;
  // Data (MEM stage) port
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_valid;
  logic                  d_stall;
  // Shared memory port
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_ack;
  // Sticky timeout flag
  logic                  err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           m_req, m_we, m_addr, m_wdata, err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           m_req, m_we, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// access. One outstanding memory transaction at a time, any ack latency,
// optional watchdog timeout (TIMEOUT = 0 disables it).
// Optional feature: define MEM_ARB_RR_EN to alternate grants under contention
// (last_grant register); otherwise the data port always wins.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.master  bus
);
  // Counter only has to reach TIMEOUT-1: the timeout fires on that cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  m_we_reg, m_we_next;
  logic [ADDR_WIDTH-1:0] m_addr_reg, m_addr_next;
  logic [DATA_WIDTH-1:0] m_wdata_reg, m_wdata_next;
  logic                  if_valid_reg, if_valid_next;
  logic [DATA_WIDTH-1:0] if_rdata_reg, if_rdata_next;
  logic                  d_valid_reg, d_valid_next;
  logic [DATA_WIDTH-1:0] d_rdata_reg, d_rdata_next;
  logic                  err_reg, err_next;
`ifdef MEM_ARB_RR_EN
  state_t                last_grant_reg, last_grant_next;
`endif

  // A requester whose completion pulse is out this cycle is still holding
  // req for the finished access; it must not win arbitration again.
  logic if_cand, d_cand, grant_d, grant_f, timeout_hit;
  assign if_cand = bus.if_req & ~if_valid_reg;
  assign d_cand  = bus.d_req & ~d_valid_reg;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Arbitration between the two candidate requesters.
  always_comb begin
    grant_d = d_cand;
`ifdef MEM_ARB_RR_EN
    if (if_cand && d_cand)
      grant_d = (last_grant_reg == FETCH);
`endif
    grant_f = if_cand & ~grant_d;
  end

  // Next-state and registered-output logic of the arbiter FSM.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    m_we_next     = m_we_reg;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    if_valid_next = 1'b0;
    if_rdata_next = if_rdata_reg;
    d_valid_next  = 1'b0;
    d_rdata_next  = d_rdata_reg;
    err_next      = err_reg;
`ifdef MEM_ARB_RR_EN
    last_grant_next = last_grant_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (grant_d) begin
          state_next   = DATA;
          m_we_next    = bus.d_we;
          m_addr_next  = bus.d_addr;
          m_wdata_next = bus.d_wdata;
`ifdef MEM_ARB_RR_EN
          last_grant_next = DATA;
`endif
        end else if (grant_f) begin
          state_next   = FETCH;
          m_we_next    = 1'b0;
          m_addr_next  = bus.if_addr;
          m_wdata_next = '0;
`ifdef MEM_ARB_RR_EN
          last_grant_next = FETCH;
`endif
        end
      end
      FETCH, DATA: begin
        if (bus.m_ack) begin
          state_next = IDLE;
          if (state_reg == FETCH) begin
            if_valid_next = 1'b1;
            if_rdata_next = bus.m_rdata;
          end else begin
            d_valid_next = 1'b1;
            d_rdata_next = m_we_reg ? '0 : bus.m_rdata;
          end
        end else if (timeout_hit) begin
          // Give up: release the requester with zero data and flag it.
          state_next = IDLE;
          err_next   = 1'b1;
          if (state_reg == FETCH) begin
            if_valid_next = 1'b1;
            if_rdata_next = '0;
          end else begin
            d_valid_next = 1'b1;
            d_rdata_next = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      if_valid_reg <= 1'b0;
      if_rdata_reg <= '0;
      d_valid_reg  <= 1'b0;
      d_rdata_reg  <= '0;
      err_reg      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_reg <= FETCH;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      m_we_reg     <= m_we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      if_valid_reg <= if_valid_next;
      if_rdata_reg <= if_rdata_next;
      d_valid_reg  <= d_valid_next;
      d_rdata_reg  <= d_rdata_next;
      err_reg      <= err_next;
`ifdef MEM_ARB_RR_EN
      last_grant_reg <= last_grant_next;
`endif
    end
  end

  assign bus.m_req    = (state_reg == FETCH) || (state_reg == DATA);
  assign bus.m_we     = m_we_reg;
  assign bus.m_addr   = m_addr_reg;
  assign bus.m_wdata  = m_wdata_reg;
  assign bus.if_valid = if_valid_reg;
  assign bus.if_rdata = if_rdata_reg;
  assign bus.d_valid  = d_valid_reg;
  assign bus.d_rdata  = d_rdata_reg;
  assign bus.err      = err_reg;
  assign bus.if_stall = bus.if_req & ~if_valid_reg;
  assign bus.d_stall  = bus.d_req & ~d_valid_reg;
endmodule
